// File: rtl/display_pkg.sv
// Shared types and helpers for the display path.
// Arbiter state encoding plus BCD bus geometry.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    SWITCH
  } arb_state_t;

  localparam int DIGITS  = 4;
  localparam int BCD_W   = DIGITS * 4;
  localparam int MAX_REQ = 8;

  // Bus is zero-extended to the widest supported arbiter.
  function automatic logic [BCD_W-1:0] bcd_slice(
    input logic [MAX_REQ*BCD_W-1:0] bus,
    input int                       idx
  );
    return bus[idx*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first request
// after last, scanning upward modulo N.
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the 4-digit display path with
// minimum hold time and a one-cycle blank between owners.
module display_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BCD_W-1:0] bcd_in,
  output logic [N_REQ-1:0]       grant,
  output logic [BCD_W-1:0]       BCD_code,
  output logic                   valid_BCD
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [IW-1:0]      last_q, last_d;

  logic [N_REQ-1:0]         win_oh;
  logic [IW-1:0]            win_idx;
  logic                     win_any;
  logic [MAX_REQ*BCD_W-1:0] bus_ext;

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (win_oh),
    .idx_o  (win_idx),
    .any_o  (win_any)
  );

  always_comb begin
    bus_ext = '0;
    bus_ext[N_REQ*BCD_W-1:0] = bcd_in;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    bcd_d   = bcd_q;
    hold_d  = hold_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE, SWITCH: begin
        state_d = IDLE;
        grant_d = '0;
        bcd_d   = '0;
        hold_d  = '0;
        if (win_any) begin
          state_d = OWN;
          grant_d = win_oh;
          last_d  = win_idx;
          bcd_d   = bcd_slice(bus_ext, int'(win_idx));
        end
      end
      OWN: begin
        bcd_d = bcd_slice(bus_ext, int'(last_q));
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        // Owner release wins over rotation.
        if ((req & grant_q) == '0 ||
            (hold_q == HOLD_MAX && (req & ~grant_q) != '0)) begin
          state_d = SWITCH;
          grant_d = '0;
          bcd_d   = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        bcd_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      bcd_q   <= '0;
      hold_q  <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      bcd_q   <= bcd_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign grant     = grant_q;
  assign BCD_code  = bcd_q;
  assign valid_BCD = |grant_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed vector bench for display_arbiter
// (3 sources, hold of 4 cycles).
module tb_display_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req;
  logic [47:0] bcd_in;
  logic [2:0]  grant;
  logic [15:0] BCD_code;
  logic        valid_BCD;

  int n_cmp;
  int n_bad;

  display_arbiter #(
    .N_REQ       (3),
    .HOLD_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .bcd_in    (bcd_in),
    .grant     (grant),
    .BCD_code  (BCD_code),
    .valid_BCD (valid_BCD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [47:0] bus;
    int          n;
    logic [2:0]  g;
    logic [15:0] bcd;
    logic        v;
  } vec_t;

  localparam logic [47:0] B0 = {16'h9ABC, 16'h1234, 16'h1111};
  localparam logic [47:0] B1 = {16'h9ABC, 16'h0042, 16'h1111};

  vec_t tbl[21];

  task automatic chk(input string nm, input int id,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h",
               nm, id, act, exp);
    end
  endtask

  task automatic chk_out(input int id, input logic [2:0] g,
                         input logic [15:0] b,
                         input logic v);
    chk("grant", id, {13'd0, grant}, {13'd0, g});
    chk("bcd", id, BCD_code, b);
    chk("valid", id, {15'd0, valid_BCD}, {15'd0, v});
    chk("onehot", id, {15'd0, $onehot0(grant)}, 16'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tbl[0]  = '{3'b111, B0, 1,  3'b001, 16'h1111, 1'b1};
    tbl[1]  = '{3'b000, B0, 1,  3'b000, 16'h0000, 1'b0};
    tbl[2]  = '{3'b000, B0, 1,  3'b000, 16'h0000, 1'b0};
    tbl[3]  = '{3'b010, B0, 1,  3'b010, 16'h1234, 1'b1};
    tbl[4]  = '{3'b010, B1, 20, 3'b010, 16'h0042, 1'b1};
    tbl[5]  = '{3'b000, B1, 1,  3'b000, 16'h0000, 1'b0};
    tbl[6]  = '{3'b011, B1, 1,  3'b001, 16'h1111, 1'b1};
    tbl[7]  = '{3'b011, B1, 4,  3'b001, 16'h1111, 1'b1};
    tbl[8]  = '{3'b011, B1, 1,  3'b000, 16'h0000, 1'b0};
    tbl[9]  = '{3'b011, B1, 5,  3'b010, 16'h0042, 1'b1};
    tbl[10] = '{3'b011, B1, 1,  3'b000, 16'h0000, 1'b0};
    tbl[11] = '{3'b011, B1, 5,  3'b001, 16'h1111, 1'b1};
    tbl[12] = '{3'b011, B1, 1,  3'b000, 16'h0000, 1'b0};
    tbl[13] = '{3'b011, B1, 2,  3'b010, 16'h0042, 1'b1};
    tbl[14] = '{3'b101, B1, 1,  3'b000, 16'h0000, 1'b0};
    tbl[15] = '{3'b101, B1, 1,  3'b100, 16'h9ABC, 1'b1};
    tbl[16] = '{3'b001, B1, 1,  3'b000, 16'h0000, 1'b0};
    tbl[17] = '{3'b001, B1, 1,  3'b001, 16'h1111, 1'b1};
    tbl[18] = '{3'b001, B1, 4,  3'b001, 16'h1111, 1'b1};
    tbl[19] = '{3'b110, B1, 1,  3'b000, 16'h0000, 1'b0};
    tbl[20] = '{3'b110, B1, 1,  3'b010, 16'h0042, 1'b1};

    // Reset held with every source requesting.
    reset_n = 1'b0;
    req     = 3'b111;
    bcd_in  = B0;
    repeat (2) @(posedge clk);
    #1;
    chk_out(-1, 3'b000, 16'h0000, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        req    = tbl[i].req;
        bcd_in = tbl[i].bus;
        @(posedge clk);
        #1;
        chk_out(i, tbl[i].g, tbl[i].bcd, tbl[i].v);
      end
    end

    // Asynchronous reset while source 1 owns the display.
    chk_out(100, 3'b010, 16'h0042, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_out(101, 3'b000, 16'h0000, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    req     = 3'b111;
    @(posedge clk);
    #1;
    chk_out(102, 3'b001, 16'h1111, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Round-robin arbiter that shares the single 4-digit 7-segment display path between several BCD sources, such as operand entry and multiplier result. It sits directly upstream of the display multiplexer and drives that block's `BCD_code`/`valid_BCD` inputs. It also grants each source the display for a guaranteed minimum hold time. A one-cycle blank separates owners, so two sources' digits never mix on the display.

## Interface
- `N_REQ`, default 3: number of requesters; range 2–8.
- `HOLD_CYCLES`, default 1000: minimum cycles an owner keeps the display while another source is waiting; must be ≥ 1.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset_n`  in  1: one clock; reset is asynchronous and active-low.
- `req`  in  N_REQ: request per source; level-sensitive; bit i is source i.
- `bcd_in`  in  N_REQ×16: packed 4-digit BCD per source; slice [16i+15:16i] is source i, with thousands in the MSB nibble.
- `grant`  out  N_REQ: one-hot or zero; current display owner.
- `BCD_code`  out  16: registered digits of the owner; 16'h0000 when there is no owner.
- `valid_BCD`  out  1: high exactly when `grant` is nonzero.

## Operation
- FSM states: IDLE, OWN, SWITCH.
- Reset values: state = IDLE; `grant` = 0; `BCD_code` = 0; `valid_BCD` = 0; hold counter = 0; round-robin pointer `last` = N_REQ-1, so source 0 wins first.
- IDLE:
  - If any `req` is high, pick the first high request scanning last+1, last+2, … modulo N_REQ.
  - Go to OWN, set `grant`, set `last` = winner, clear the hold counter.
- OWN:
  - Every cycle, `BCD_code` <= the owner's `bcd_in` slice, so owner updates propagate continuously.
  - The hold counter increments and saturates at HOLD_CYCLES.
  - If the owner's `req` drops: go to SWITCH. The drop takes precedence over everything else.
  - Else if the counter equals HOLD_CYCLES and another `req` is high: go to SWITCH (rotation).
  - Otherwise stay in OWN; a sole requester keeps the display indefinitely.
- SWITCH (exactly one cycle):
  - `grant` = 0, `valid_BCD` = 0, `BCD_code` = 0.
  - Next cycle, re-arbitrate as in IDLE from the updated `last`.
  - If no requests are pending, go to IDLE.
- A source that requests during SWITCH is considered in the following arbitration.
- `bcd_in` of non-owners is ignored. Digit values above 9 pass through unchanged; the display decoder blanks them.
- If `reset_n` is asserted mid-operation, all state returns to reset values immediately. This is asynchronous and no SWITCH blank is generated.

## Timing
- Request to display: `req` first high at edge t in IDLE gives `grant`/`valid_BCD`/`BCD_code` valid after edge t+1 (1-cycle latency).
- Data path: a change on the owner's `bcd_in` at edge t appears on `BCD_code` after edge t+1.
- Rotation with competitor waiting: the owner holds for HOLD_CYCLES+1 cycles of `valid_BCD`. There is then 1 blank cycle, and the next owner is valid 1 cycle later.
- Owner release: the owner's `req` low at edge t gives `grant` = 0 after edge t+1, and the new owner appears after edge t+2.
- `grant` and `valid_BCD` always change on the same edge. They are never both asserted for two different sources.

## Structure
- Shared package `display_pkg`:
  - typedef enum `arb_state_t` {IDLE, OWN, SWITCH};
  - constants `DIGITS` = 4 and `BCD_W` = 16;
  - function `bcd_slice(bus, idx)`.
- Sub-module `rr_picker`: combinational. Inputs are `req` and `last`; outputs are the one-hot winner and its index. It is reused by any later arbiter.
- FSM, hold counter, `last` register and output registers live in `display_arbiter`.

## Test plan
- Reset: hold `reset_n` = 0 with `req` = 3'b111. Required response: `grant` = 0, `valid_BCD` = 0, `BCD_code` = 0. After release, `grant` = 3'b001 one cycle later.
- Single requester: `req` = 3'b010 with bcd_in[1] = 16'h1234. Required response: after 1 cycle `grant` = 3'b010 and `BCD_code` = 16'h1234. Changing bcd_in[1] to 16'h0042 appears 1 cycle later. There is no rotation over 5×HOLD_CYCLES.
- Rotation (HOLD_CYCLES = 4): `req` = 3'b011 constant. Required response: grants alternate 001, 010, 001, … Each grant lasts 5 cycles, separated by one cycle with `valid_BCD` = 0.
- Early release: the owner drops `req` after 2 cycles while another source is waiting. Required response: 1 blank cycle, then the next source is granted. `last` order is respected (source 2 after 1, then 0).
- Simultaneous events: the owner drops `req` on the same edge its hold expires and another source rises. Required response: exactly one SWITCH cycle, then the new owner; `grant` is never two-hot.
- Mid-operation reset: assert `reset_n` = 0 while in OWN. Required response: outputs are zero before the next clock edge. After release, arbitration restarts from source 0.
